// File: rtl/tea_pkg.sv
// Shared types and constants for the TEA scheduler and its arbiter.
package tea_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } state_t;

    localparam int          BLOCK_W = 64;
    localparam int          KEY_W   = 128;
    localparam logic [31:0] DELTA   = 32'h9E3779B9;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1,
// wrapping modulo NUM_CH, and returns the first requesting channel.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_last_grant,
    output logic [NUM_CH-1:0] o_grant_oh,
    output logic [CH_W-1:0]   o_grant_idx,
    output logic              o_any
);

    // Rotating priority search; the found flag keeps only the first hit.
    always_comb begin
        logic            found;
        logic [CH_W-1:0] idx;
        found       = 1'b0;
        idx         = '0;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx = CH_W'((int'(i_last_grant) + off) % NUM_CH);
            if (!found && i_req[idx]) begin
                found           = 1'b1;
                o_grant_idx     = idx;
                o_grant_oh[idx] = 1'b1;
            end
        end
        o_any = found;
    end

endmodule

// File: rtl/tea_scheduler.sv
// Shares one iterative TEA core between NUM_CH input streams, one block in
// flight, and returns each ciphertext tagged with its source channel.
//
// Handshake rule on every stream here: a transfer happens on a rising edge
// where valid and ready are both high; a source that raises valid keeps it
// and its payload stable until that transfer; ready may depend on valid.
module tea_scheduler
    import tea_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [KEY_W-1:0]          i_key,
    input  logic [NUM_CH-1:0]         i_axis_valid_s,
    output logic [NUM_CH-1:0]         o_axis_ready_s,
    input  logic [NUM_CH*BLOCK_W-1:0] i_axis_data_s,
    output logic                      o_core_valid,
    input  logic                      i_core_ready,
    output logic [BLOCK_W-1:0]        o_core_data,
    output logic [KEY_W-1:0]          o_core_key,
    input  logic                      i_core_valid,
    output logic                      o_core_ready,
    input  logic [BLOCK_W-1:0]        i_core_data,
    output logic                      o_axis_valid_m,
    input  logic                      i_axis_ready_m,
    output logic [BLOCK_W-1:0]        o_axis_data_m,
    output logic [CH_W-1:0]           o_axis_tid_m,
    output logic                      o_busy,
    output logic [31:0]               o_blocks_done,
    output logic [1:0]                o_dbg_state
);

    state_t               state_q, state_d;
    logic [CH_W-1:0]      last_grant_q;
    logic [BLOCK_W-1:0]   blk_q, res_q, sel_blk;
    logic [KEY_W-1:0]     key_q;
    logic [CH_W-1:0]      tid_q;
    logic [31:0]          done_q;
    logic [NUM_CH-1:0]    grant_oh;
    logic [CH_W-1:0]      grant_idx;
    logic                 grant_any;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .i_req        (i_axis_valid_s),
        .i_last_grant (last_grant_q),
        .o_grant_oh   (grant_oh),
        .o_grant_idx  (grant_idx),
        .o_any        (grant_any)
    );

    // Pick the granted channel's block out of the flattened input bus.
    always_comb begin
        sel_blk = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_idx == CH_W'(c)) sel_blk = i_axis_data_s[c*BLOCK_W +: BLOCK_W];
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake outputs; each state owns exactly one handshake.
    always_comb begin
        state_d        = state_q;
        o_axis_ready_s = '0;
        o_core_valid   = 1'b0;
        o_core_ready   = 1'b0;
        o_axis_valid_m = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    o_axis_ready_s = grant_oh;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                o_core_valid = 1'b1;
                if (i_core_ready) state_d = WAIT;
            end
            WAIT: begin
                o_core_ready = 1'b1;
                if (i_core_valid) state_d = RETURN;
            end
            RETURN: begin
                o_axis_valid_m = 1'b1;
                if (i_axis_ready_m) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Block, key and tag are captured only at grant so later input changes
    // cannot disturb the block in flight; the result is captured from the core.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant_q <= CH_W'(NUM_CH - 1);
            blk_q        <= '0;
            key_q        <= '0;
            tid_q        <= '0;
            res_q        <= '0;
            done_q       <= '0;
        end else begin
            if (state_q == IDLE && grant_any) begin
                blk_q        <= sel_blk;
                key_q        <= i_key;
                tid_q        <= grant_idx;
                last_grant_q <= grant_idx;
            end
            if (state_q == WAIT && i_core_valid) res_q <= i_core_data;
            if (state_q == RETURN && i_axis_ready_m) done_q <= done_q + 32'd1;
        end
    end

    assign o_core_data   = blk_q;
    assign o_core_key    = key_q;
    assign o_axis_data_m = res_q;
    assign o_axis_tid_m  = tid_q;
    assign o_blocks_done = done_q;
    assign o_busy        = (state_q != IDLE);
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_tea_scheduler.sv
// Bench for tea_scheduler: per-channel source queues, an iterative TEA core
// model (one round per cycle) and a scoreboard fed by the directed tests.
module tb_tea_scheduler;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [127:0]          cur_key = '0;
    logic [NUM_CH-1:0]     s_valid = '0;
    logic [NUM_CH-1:0]     s_ready;
    logic [NUM_CH*64-1:0]  s_data = '0;
    logic                  c_in_valid;
    logic                  c_in_ready = 1'b0;
    logic [63:0]           c_in_data;
    logic [127:0]          c_in_key;
    logic                  c_out_valid = 1'b0;
    logic                  c_out_ready;
    logic [63:0]           c_out_data = '0;
    logic                  m_valid;
    logic                  m_ready = 1'b1;
    logic [63:0]           m_data;
    logic [CH_W-1:0]       m_tid;
    logic                  busy;
    logic [31:0]           blocks_done;
    logic [1:0]            dbg_state;

    tea_scheduler #(.NUM_CH(NUM_CH)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_key          (cur_key),
        .i_axis_valid_s (s_valid),
        .o_axis_ready_s (s_ready),
        .i_axis_data_s  (s_data),
        .o_core_valid   (c_in_valid),
        .i_core_ready   (c_in_ready),
        .o_core_data    (c_in_data),
        .o_core_key     (c_in_key),
        .i_core_valid   (c_out_valid),
        .o_core_ready   (c_out_ready),
        .i_core_data    (c_out_data),
        .o_axis_valid_m (m_valid),
        .i_axis_ready_m (m_ready),
        .o_axis_data_m  (m_data),
        .o_axis_tid_m   (m_tid),
        .o_busy         (busy),
        .o_blocks_done  (blocks_done),
        .o_dbg_state    (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [65:0] exp_q[$];          // {tid, ciphertext}
    logic [31:0] exp_done = '0;
    logic [63:0] src_q[NUM_CH][$];
    logic [NUM_CH-1:0] hs = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference TEA encryption, v0 = upper word, k0 = key[127:96].
    function automatic logic [63:0] tea_enc(input logic [63:0] b, input logic [127:0] k);
        logic [31:0] v0, v1, sum;
        v0 = b[63:32]; v1 = b[31:0]; sum = '0;
        for (int r = 0; r < 32; r++) begin
            sum = sum + 32'h9E3779B9;
            v0  = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
            v1  = v1 + (((v0 << 4) + k[63:32])  ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
        end
        return {v0, v1};
    endfunction

    task automatic push_exp(input logic [63:0] blk, input logic [127:0] k, input logic [1:0] tid);
        exp_q.push_back({tid, tea_enc(blk, k)});
    endtask

    // ---------------- source driver ----------------
    always @(negedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (hs[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
            hs[c] = 1'b0;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            s_valid[c]         = (src_q[c].size() > 0);
            s_data[c*64 +: 64] = (src_q[c].size() > 0) ? src_q[c][0] : 64'h0;
        end
        #1;
        for (int c = 0; c < NUM_CH; c++)
            if (s_valid[c] && s_ready[c] && !rst) hs[c] = 1'b1;
    end

    // ---------------- core model: L = 32 rounds ----------------
    logic [31:0]  cm_v0, cm_v1, cm_sum;
    logic [127:0] cm_k;
    logic         cm_busy = 1'b0;
    int           cm_cnt  = 0;
    always @(posedge clk) begin
        logic [31:0] s, n0, n1;
        if (rst) begin
            cm_busy     <= 1'b0;
            c_out_valid <= 1'b0;
            c_in_ready  <= 1'b1;
        end else if (c_out_valid) begin
            if (c_out_ready) begin
                c_out_valid <= 1'b0;
                c_in_ready  <= 1'b1;
            end
        end else if (cm_busy) begin
            s  = cm_sum + 32'h9E3779B9;
            n0 = cm_v0 + (((cm_v1 << 4) + cm_k[127:96]) ^ (cm_v1 + s) ^ ((cm_v1 >> 5) + cm_k[95:64]));
            n1 = cm_v1 + (((n0 << 4) + cm_k[63:32]) ^ (n0 + s) ^ ((n0 >> 5) + cm_k[31:0]));
            cm_v0  <= n0;
            cm_v1  <= n1;
            cm_sum <= s;
            cm_cnt <= cm_cnt + 1;
            if (cm_cnt == 31) begin
                cm_busy     <= 1'b0;
                c_out_valid <= 1'b1;
                c_out_data  <= {n0, n1};
            end
        end else if (c_in_valid && c_in_ready) begin
            cm_v0      <= c_in_data[63:32];
            cm_v1      <= c_in_data[31:0];
            cm_k       <= c_in_key;
            cm_sum     <= '0;
            cm_cnt     <= 0;
            cm_busy    <= 1'b1;
            c_in_ready <= 1'b0;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [65:0] e;
        #3;
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {64'h0, m_data}, 128'h0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", {64'h0, m_data}, {64'h0, e[63:0]});
                check("out_tid", {126'h0, m_tid}, {126'h0, e[65:64]});
                check("blocks_done_at_hs", {96'h0, blocks_done}, {96'h0, exp_done});
                exp_done = exp_done + 32'd1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "_ready_s"},  {124'h0, s_ready}, 128'h0);
        check({tag, "_core_v"},   {127'h0, c_in_valid}, 128'h0);
        check({tag, "_core_d"},   {64'h0, c_in_data}, 128'h0);
        check({tag, "_core_k"},   c_in_key, 128'h0);
        check({tag, "_core_r"},   {127'h0, c_out_ready}, 128'h0);
        check({tag, "_m_valid"},  {127'h0, m_valid}, 128'h0);
        check({tag, "_m_data"},   {64'h0, m_data}, 128'h0);
        check({tag, "_m_tid"},    {126'h0, m_tid}, 128'h0);
        check({tag, "_busy"},     {127'h0, busy}, 128'h0);
        check({tag, "_done"},     {96'h0, blocks_done}, 128'h0);
        check({tag, "_state"},    {126'h0, dbg_state}, 128'h0);
    endtask

    task automatic drain(input string tag);
        int n;
        logic pend;
        n = 0;
        pend = 1'b1;
        while (pend && n < 3000) begin
            @(negedge clk); #4;
            n++;
            pend = (exp_q.size() != 0) || busy;
            for (int c = 0; c < NUM_CH; c++) if (src_q[c].size() != 0) pend = 1'b1;
        end
        check({tag, "_drain_timeout"}, {127'h0, pend}, 128'h0);
    endtask

    task automatic wait_core_ready(input string tag);
        int n;
        n = 0;
        while (!c_out_ready && n < 500) begin
            @(negedge clk); #2;
            n++;
        end
        check({tag, "_wait_state_timeout"}, {127'h0, c_out_ready}, 128'h1);
    endtask

    task automatic wait_out_valid(input string tag);
        int n;
        n = 0;
        while (!m_valid && n < 500) begin
            @(negedge clk); #2;
            n++;
        end
        check({tag, "_return_timeout"}, {127'h0, m_valid}, 128'h1);
    endtask

    // ---------------- directed tests ----------------
    localparam logic [127:0] KB = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    localparam logic [127:0] KC = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678;
    localparam logic [127:0] KD = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] KE = 128'hFFFF_0000_FFFF_0000_AAAA_5555_AAAA_5555;
    localparam logic [127:0] KF = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check_all_zero("reset");
        rst = 1'b0;

        // Single block from channel 0, key 0
        cur_key = '0;
        src_q[0].push_back(64'h0123_4567_89AB_CDEF);
        push_exp(64'h0123_4567_89AB_CDEF, 128'h0, 2'd0);
        drain("single");
        check("single_done", {96'h0, blocks_done}, 128'd1);

        // Reset so channel 0 wins again, then all four channels requesting
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #2;
        check("rst2_done", {96'h0, blocks_done}, 128'd0);
        rst = 1'b0;
        exp_done = '0;
        cur_key = KB;
        src_q[0].push_back(64'hA000_0000_0000_0000);
        src_q[0].push_back(64'hA444_4444_4444_4444);
        src_q[1].push_back(64'hA111_1111_1111_1111);
        src_q[2].push_back(64'hA222_2222_2222_2222);
        src_q[3].push_back(64'hA333_3333_3333_3333);
        push_exp(64'hA000_0000_0000_0000, KB, 2'd0);
        push_exp(64'hA111_1111_1111_1111, KB, 2'd1);
        push_exp(64'hA222_2222_2222_2222, KB, 2'd2);
        push_exp(64'hA333_3333_3333_3333, KB, 2'd3);
        push_exp(64'hA444_4444_4444_4444, KB, 2'd0);
        drain("all4");
        check("all4_done", {96'h0, blocks_done}, 128'd5);

        // Serve channel 3, then only channel 2: granted in the first IDLE cycle
        src_q[3].push_back(64'hB333_0000_3333_0000);
        push_exp(64'hB333_0000_3333_0000, KB, 2'd3);
        drain("ch3");
        src_q[2].push_back(64'hB222_0000_2222_0000);
        push_exp(64'hB222_0000_2222_0000, KB, 2'd2);
        @(negedge clk); #2;
        check("ch2_first_grant", {124'h0, s_ready}, 128'h4);
        drain("ch2");

        // Downstream stall in RETURN for 10 cycles
        @(negedge clk);
        m_ready = 1'b0;
        cur_key = KC;
        src_q[0].push_back(64'hC000_1111_2222_3333);
        src_q[1].push_back(64'hC111_4444_5555_6666);
        push_exp(64'hC000_1111_2222_3333, KC, 2'd0);
        push_exp(64'hC111_4444_5555_6666, KC, 2'd1);
        wait_out_valid("stall");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #2;
            check("stall_valid", {127'h0, m_valid}, 128'h1);
            check("stall_data", {64'h0, m_data}, {64'h0, tea_enc(64'hC000_1111_2222_3333, KC)});
            check("stall_tid", {126'h0, m_tid}, 128'h0);
            check("stall_no_grant", {124'h0, s_ready}, 128'h0);
        end
        @(negedge clk);
        m_ready = 1'b1;
        drain("stall");

        // Key and channel data change while the block is in WAIT
        cur_key = KD;
        src_q[2].push_back(64'hD000_AAAA_BBBB_CCCC);
        push_exp(64'hD000_AAAA_BBBB_CCCC, KD, 2'd2);
        wait_core_ready("keychg");
        @(negedge clk);
        cur_key = KE;
        src_q[2].push_back(64'hD111_9999_8888_7777);
        push_exp(64'hD111_9999_8888_7777, KE, 2'd2);
        @(negedge clk); #2;
        check("keychg_core_key", c_in_key, KD);
        check("keychg_core_data", {64'h0, c_in_data}, {64'h0, 64'hD000_AAAA_BBBB_CCCC});
        drain("keychg");

        // Reset during WAIT discards the block; channel 0 wins afterwards
        src_q[3].push_back(64'hE333_0000_0000_0001);
        wait_core_ready("rstwait");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #2;
        check_all_zero("rstwait");
        rst = 1'b0;
        exp_done = '0;
        cur_key = KF;
        src_q[0].push_back(64'hF000_0000_0000_00F0);
        src_q[1].push_back(64'hF111_0000_0000_00F1);
        push_exp(64'hF000_0000_0000_00F0, KF, 2'd0);
        push_exp(64'hF111_0000_0000_00F1, KF, 2'd1);
        @(negedge clk); #2;
        check("rstwait_ch0_first", {124'h0, s_ready}, 128'h1);
        drain("rstwait");
        check("rstwait_done", {96'h0, blocks_done}, 128'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
